// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter
//   Round-robin arbiter that shares one uart_mmio bus port between NREQ
//   requesters. Each granted single-beat access becomes exactly one
//   write_enable or read_enable strobe cycle toward uart_mmio, so the
//   uart_mmio FIFO pointers advance once per granted access.
//   Sequence per access: IDLE (arbitrate, latch) -> XFER (strobe) -> RESP (ack).
//
// Optional feature: define UART_ARB_LOCK_EN to honour the lock input.
//   A locked owner may re-issue straight from RESP to XFER, skipping
//   rotation, for up to HOLD_MAX consecutive grants. Without the macro the
//   lock input is ignored.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req/we/lock [NREQ]         per-requester request level, write select, lock
//   addr [NREQ*ADDR_W]         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata [NREQ*DATA_W]        packed write data, same packing
//   ack [NREQ]                 one-cycle completion pulse to the owner
//   rdata                      read result, valid while ack is high (0 on writes)
//   owner                      index of the current/last granted requester
//   m_addr, m_write_data       to uart_mmio, hold last values while idle
//   m_write_enable/m_read_enable  one-cycle strobes to uart_mmio
//   m_read_data                from uart_mmio (combinational on that side)

module uart_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4,
    localparam int OW      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [OW-1:0]            owner,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_write_data,
    output logic                     m_write_enable,
    output logic                     m_read_enable,
    input  logic [DATA_W-1:0]        m_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [OW-1:0]   rr_ptr;
    logic            lat_we;

    // control from the FSM to the datapath
    logic            ld;        // latch a new transaction from requester ld_idx
    logic [OW-1:0]   ld_idx;
    logic            rotate;    // transaction finished, advance rr_ptr past owner
    logic            relock;    // locked owner re-issues without rotation

    // round-robin pick: first set req bit scanning upward from rr_ptr with wrap
    logic            any_req;
    logic [OW-1:0]   pick;
    int              idx;

    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = OW'(idx);
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_cnt;   // grants given to the current owner in a row
    logic          lock_ok;

    // Once hold_cnt reaches HOLD_MAX the owner falls back to normal rotation,
    // which lets any other pending requester in ahead of it.
    assign lock_ok = lock[owner] && req[owner] && (hold_cnt < HW'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= '0;
        else if (relock)
            hold_cnt <= hold_cnt + 1'b1;
        else if (ld)
            hold_cnt <= HW'(1);
        else if (rotate)
            hold_cnt <= '0;
    end
`else
    logic lock_ok;
    logic unused_lock;
    assign lock_ok     = 1'b0;
    assign unused_lock = ^lock;
    localparam int unused_hold_max = HOLD_MAX;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state and strobes; ack and strobes decode straight from state so a
    // reset edge kills them immediately with no partial ack
    always_comb begin
        state_n        = state;
        ld             = 1'b0;
        ld_idx         = owner;
        rotate         = 1'b0;
        relock         = 1'b0;
        ack            = '0;
        m_write_enable = 1'b0;
        m_read_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    ld      = 1'b1;
                    ld_idx  = pick;
                    state_n = XFER;
                end
            end
            XFER: begin
                m_write_enable = lat_we;
                m_read_enable  = !lat_we;
                state_n        = RESP;
            end
            RESP: begin
                ack[owner] = 1'b1;
                if (lock_ok) begin
                    relock  = 1'b1;
                    ld_idx  = owner;
                    state_n = XFER;
                end else begin
                    rotate  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath latches; m_addr/m_write_data are the latches themselves, so
    // they keep their last values while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= '0;
            m_addr       <= '0;
            m_write_data <= '0;
            lat_we       <= 1'b0;
            rdata        <= '0;
            rr_ptr       <= '0;
        end else begin
            if (ld || relock) begin
                owner        <= ld_idx;
                m_addr       <= addr[int'(ld_idx)*ADDR_W +: ADDR_W];
                m_write_data <= wdata[int'(ld_idx)*DATA_W +: DATA_W];
                lat_we       <= we[ld_idx];
            end
            if (state == XFER)
                rdata <= lat_we ? '0 : m_read_data;
            if (rotate)
                rr_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
    end

endmodule
